// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit and its ALU decoder.
package mcu_pkg;

  // Controller states; the value is exported on state_dbg.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BR     = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_e;

  // Opcodes recognised in DECODE
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Internal ALUOp between the state decode and the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes (4-bit form; base codes fit in 3 bits)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  // Datapath mux selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps ALUOp and instruction fields to the ALU operation code.
module mc_alu_decoder
  import mcu_pkg::*;
#(
  parameter bit          EXT_ALU = 1'b0,
  parameter int unsigned ACW     = EXT_ALU ? 4 : 3
) (
  input  logic [1:0]     aluop,
  input  logic           op5,
  input  logic [2:0]     func3,
  input  logic           func7,
  output logic [ACW-1:0] alucontrol
);

  logic [3:0] code;

  // Operation select; undecoded func3 values fall back to add
  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (func3)
          3'b000:  code = (op5 & func7) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          3'b100:  if (EXT_ALU) code = ALU_XOR;
          3'b001:  if (EXT_ALU) code = ALU_SLL;
          3'b101:  if (EXT_ALU) code = func7 ? ALU_SRA : ALU_SRL;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alucontrol = ACW'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: state register plus Moore strobe decode.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter bit          MEM_WAIT    = 1'b1,
  parameter bit          EXT_ALU     = 1'b0,
  parameter bit          SUPPORT_BNE = 1'b1,
  parameter int unsigned ACW         = EXT_ALU ? 4 : 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [6:0]     op,
  input  logic [2:0]     func3,
  input  logic           func7,
  input  logic           Zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           PCWrite,
  output logic           AdrSrc,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic [1:0]     ResultSrc,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ImmSrc,
  output logic           RegWrite,
  output logic [ACW-1:0] ALUControl,
  output logic           illegal,
  output logic [3:0]     state_dbg
);

  state_e     state;
  logic       rdy;
  logic [1:0] aluop;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  // State transitions; reset aborts whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (rdy) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXER;
            OP_ITYPE:     state <= S_EXEI;
            OP_BRANCH:    state <= S_BR;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_TRAP;
          endcase
        end
        S_MEMADR: state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (rdy) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (rdy) state <= S_FETCH;
        S_EXER:   state <= S_ALUWB;
        S_EXEI:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BR:     state <= S_FETCH;
        S_JAL:    state <= S_ALUWB;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Strobe decode from state; write strobes are masked while rst is high
  always_comb begin
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    RegWrite  = 1'b0;
    aluop     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = rdy;
        PCWrite   = rdy;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
      end
      S_EXEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_SUB;
        if (func3 == 3'b000)
          PCWrite = Zero;
        else if (func3 == 3'b001 && SUPPORT_BNE)
          PCWrite = ~Zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign illegal   = (state == S_TRAP) && !rst;
  assign state_dbg = state;

  mc_alu_decoder #(
    .EXT_ALU(EXT_ALU)
  ) u_alu_decoder (
    .aluop      (aluop),
    .op5        (op[5]),
    .func3      (func3),
    .func7      (func7),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (default parameters and
// MEM_WAIT=0/EXT_ALU=1/SUPPORT_BNE=0) checked cycle by cycle against
// per-instruction expected step lists.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] func3 = '0;
  logic       func7 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       mreq[2], pcw[2], adr[2], memw[2], irw[2], regw[2], ill[2];
  logic [1:0] rsrc[2], asa[2], asb[2], imm[2];
  logic [3:0] sdbg[2];
  logic [2:0] aluc0;
  logic [3:0] aluc1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, pcw, adr, memw, irw;
    logic [1:0] rsrc, asa, asb, imm;
    logic       regw;
    logic [3:0] aluc;
    logic       ill;
  } obs_t;

  typedef struct {
    logic mr;
    logic r;
    obs_t e;
  } step_t;

  step_t q[$];

  multicycle_control_unit #(.MEM_WAIT(1), .EXT_ALU(0), .SUPPORT_BNE(1)) dut0 (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mreq[0]), .PCWrite(pcw[0]), .AdrSrc(adr[0]),
    .MemWrite(memw[0]), .IRWrite(irw[0]), .ResultSrc(rsrc[0]), .ALUSrcA(asa[0]),
    .ALUSrcB(asb[0]), .ImmSrc(imm[0]), .RegWrite(regw[0]), .ALUControl(aluc0),
    .illegal(ill[0]), .state_dbg(sdbg[0]));

  multicycle_control_unit #(.MEM_WAIT(0), .EXT_ALU(1), .SUPPORT_BNE(0)) dut1 (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mreq[1]), .PCWrite(pcw[1]), .AdrSrc(adr[1]),
    .MemWrite(memw[1]), .IRWrite(irw[1]), .ResultSrc(rsrc[1]), .ALUSrcA(asa[1]),
    .ALUSrcB(asb[1]), .ImmSrc(imm[1]), .RegWrite(regw[1]), .ALUControl(aluc1),
    .illegal(ill[1]), .state_dbg(sdbg[1]));

  always #5 clk = ~clk;

  function automatic obs_t get_obs(int k);
    obs_t o;
    o.st = sdbg[k]; o.mreq = mreq[k]; o.pcw = pcw[k]; o.adr = adr[k];
    o.memw = memw[k]; o.irw = irw[k]; o.rsrc = rsrc[k]; o.asa = asa[k];
    o.asb = asb[k]; o.imm = imm[k]; o.regw = regw[k]; o.ill = ill[k];
    o.aluc = (k == 0) ? {1'b0, aluc0} : aluc1;
    return o;
  endfunction

  // Expected outputs of one state, straight from the strobe table.
  function automatic obs_t stage(state_e s, logic flag, logic [3:0] alu);
    obs_t e = '0;
    e.st = s;
    case (s)
      S_FETCH:  begin e.mreq = 1; e.asb = 2; e.rsrc = 2; e.irw = flag; e.pcw = flag; end
      S_DECODE: begin e.asa = 1; e.asb = 1; e.imm = 2; end
      S_MEMADR: begin e.asa = 2; e.asb = 1; e.imm = flag ? 2'd1 : 2'd0; end
      S_MEMRD:  begin e.mreq = 1; e.adr = 1; end
      S_MEMWB:  begin e.rsrc = 1; e.regw = 1; end
      S_MEMWR:  begin e.mreq = 1; e.adr = 1; e.memw = 1; end
      S_EXER:   begin e.asa = 2; e.aluc = alu; end
      S_EXEI:   begin e.asa = 2; e.asb = 1; e.aluc = alu; end
      S_ALUWB:  begin e.regw = 1; end
      S_BR:     begin e.asa = 2; e.aluc = 4'd1; e.pcw = flag; end
      S_JAL:    begin e.asa = 1; e.asb = 2; e.pcw = 1; end
      S_TRAP:   begin e.ill = 1; end
      default:  ;
    endcase
    return e;
  endfunction

  function automatic obs_t rst_mask(obs_t e);
    obs_t m = e;
    m.mreq = 0; m.pcw = 0; m.memw = 0; m.irw = 0; m.regw = 0; m.ill = 0;
    return m;
  endfunction

  function automatic logic [3:0] ref_alu(int k, logic [6:0] o, logic [2:0] f3, logic f7);
    logic ext = (k == 1);
    case (f3)
      3'd0:    return (o[5] && f7) ? 4'd1 : 4'd0;
      3'd2:    return 4'd5;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      3'd4:    return ext ? 4'd4 : 4'd0;
      3'd1:    return ext ? 4'd6 : 4'd0;
      3'd5:    return ext ? (f7 ? 4'd8 : 4'd7) : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  function automatic void push(logic mr, logic r, obs_t e);
    step_t s;
    s.mr = mr; s.r = r; s.e = e;
    q.push_back(s);
  endfunction

  // A memory-handshake phase: w stalled cycles, then the completing cycle.
  // Instance 1 ignores mem_ready, so it completes at once even with it low.
  function automatic void push_wait(int k, int w, obs_t ew, obs_t ed);
    if (k == 0) begin
      for (int i = 0; i < w; i++) push(1'b0, 1'b0, ew);
      push(1'b1, 1'b0, ed);
    end else begin
      push(1'b0, 1'b0, ed);
    end
  endfunction

  // Builds the full expected cycle list for one instruction.
  task automatic gen(int k, logic [6:0] o, logic [2:0] f3, logic f7, logic z, int wf, int wm);
    logic take;
    op = o; func3 = f3; func7 = f7; Zero = z;
    q.delete();
    push_wait(k, wf, stage(S_FETCH, 0, 0), stage(S_FETCH, 1, 0));
    push(1'b1, 1'b0, stage(S_DECODE, 0, 0));
    case (o)
      7'b0000011: begin
        push(1'b1, 1'b0, stage(S_MEMADR, 0, 0));
        push_wait(k, wm, stage(S_MEMRD, 0, 0), stage(S_MEMRD, 0, 0));
        push(1'b1, 1'b0, stage(S_MEMWB, 0, 0));
      end
      7'b0100011: begin
        push(1'b1, 1'b0, stage(S_MEMADR, 1, 0));
        push_wait(k, wm, stage(S_MEMWR, 0, 0), stage(S_MEMWR, 0, 0));
      end
      7'b0110011: begin
        push(1'b1, 1'b0, stage(S_EXER, 0, ref_alu(k, o, f3, f7)));
        push(1'b1, 1'b0, stage(S_ALUWB, 0, 0));
      end
      7'b0010011: begin
        push(1'b1, 1'b0, stage(S_EXEI, 0, ref_alu(k, o, f3, f7)));
        push(1'b1, 1'b0, stage(S_ALUWB, 0, 0));
      end
      7'b1100011: begin
        take = (f3 == 3'd0) ? z : ((f3 == 3'd1 && k == 0) ? ~z : 1'b0);
        push(1'b1, 1'b0, stage(S_BR, take, 0));
      end
      7'b1101111: begin
        push(1'b1, 1'b0, stage(S_JAL, 0, 0));
        push(1'b1, 1'b0, stage(S_ALUWB, 0, 0));
      end
      default: begin
        for (int i = 0; i < 3; i++) push(1'(i % 2), 1'b0, stage(S_TRAP, 0, 0));
        push(1'b1, 1'b1, rst_mask(stage(S_TRAP, 0, 0)));
      end
    endcase
  endtask

  task automatic drive_step(input step_t s, input int k, output obs_t o);
    @(negedge clk);
    mem_ready = s.mr;
    rst = s.r;
    #1;
    o = get_obs(k);
  endtask

  // Puts both instances back in FETCH at the next edge.
  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    e = rst_mask(stage(S_FETCH, 1, 0));
    for (int k = 0; k < 2; k++) begin
      step_t s;
      s.mr = 1'b1; s.r = 1'b1; s.e = e;
      drive_step(s, k, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset dut%0d: got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic run_instr(string name, int k, logic [6:0] o, logic [2:0] f3,
                           logic f7, logic z, int wf, int wm);
    obs_t ob;
    sync_reset();
    gen(k, o, f3, f7, z, wf, wm);
    foreach (q[i]) begin
      drive_step(q[i], k, ob);
      total++;
      if (ob !== q[i].e) begin
        bad++;
        $display("FAIL %s dut%0d cyc%0d: got %h want %h", name, k, i, ob, q[i].e);
      end
    end
  endtask

  task automatic test_lw();
    run_instr("lw", 0, 7'b0000011, 3'd2, 0, 0, 0, 0);
    run_instr("lw_wait", 0, 7'b0000011, 3'd2, 0, 0, 1, 2);
  endtask

  task automatic test_sw_wait();
    obs_t ob;
    int wr_cycles;
    sync_reset();
    gen(0, 7'b0100011, 3'd2, 0, 0, 0, 2);
    wr_cycles = 0;
    foreach (q[i]) begin
      drive_step(q[i], 0, ob);
      if (ob.memw === 1'b1) wr_cycles++;
      total++;
      if (ob !== q[i].e) begin
        bad++;
        $display("FAIL sw_wait cyc%0d: got %h want %h", i, ob, q[i].e);
      end
    end
    total++;
    if (wr_cycles !== 3) begin
      bad++;
      $display("FAIL sw_memwrite_len: got %0d want 3", wr_cycles);
    end
  endtask

  task automatic test_alu();
    run_instr("r_sub", 0, 7'b0110011, 3'd0, 1, 0, 0, 0);
    run_instr("r_sra_ext", 1, 7'b0110011, 3'd5, 1, 0, 0, 0);
    run_instr("i_srl_ext", 1, 7'b0010011, 3'd5, 0, 0, 0, 0);
    run_instr("i_addi_f7", 0, 7'b0010011, 3'd0, 1, 0, 0, 0);
    run_instr("r_xor_base", 0, 7'b0110011, 3'd4, 0, 0, 0, 0);
    run_instr("jal", 0, 7'b1101111, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr("beq_z1", 0, 7'b1100011, 3'd0, 0, 1, 0, 0);
    run_instr("beq_z0", 0, 7'b1100011, 3'd0, 0, 0, 0, 0);
    run_instr("bne_z1", 0, 7'b1100011, 3'd1, 0, 1, 0, 0);
    run_instr("bne_z0", 0, 7'b1100011, 3'd1, 0, 0, 0, 0);
    run_instr("bne_nosup", 1, 7'b1100011, 3'd1, 0, 0, 0, 0);
    run_instr("blt_other", 0, 7'b1100011, 3'd4, 0, 1, 0, 0);
  endtask

  task automatic test_trap();
    run_instr("trap", 0, 7'b0000000, 3'd0, 0, 0, 0, 0);
    // After the one reset edge the unit must fetch with illegal low.
    run_instr("after_trap", 0, 7'b0110011, 3'd7, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midwait();
    obs_t ob;
    sync_reset();
    op = 7'b0000011; func3 = 3'd2; func7 = 0; Zero = 0;
    q.delete();
    push(1'b1, 1'b0, stage(S_FETCH, 1, 0));
    push(1'b1, 1'b0, stage(S_DECODE, 0, 0));
    push(1'b1, 1'b0, stage(S_MEMADR, 0, 0));
    push(1'b0, 1'b0, stage(S_MEMRD, 0, 0));
    push(1'b0, 1'b1, rst_mask(stage(S_MEMRD, 0, 0)));
    push(1'b0, 1'b0, stage(S_FETCH, 0, 0));
    foreach (q[i]) begin
      drive_step(q[i], 0, ob);
      total++;
      if (ob !== q[i].e) begin
        bad++;
        $display("FAIL rst_midwait cyc%0d: got %h want %h", i, ob, q[i].e);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[7];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b1110011;
    for (int n = 0; n < 80; n++) begin
      int k   = int'($urandom_range(0, 1));
      int sel = int'($urandom_range(0, 12));
      logic [6:0] o = ops[(sel > 6) ? sel - 6 : sel];
      run_instr("random", k, o, 3'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu();
    test_branch();
    test_trap();
    test_reset_midwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
